// File: rtl/cache_port_arbiter.sv
// Shares one cache port between fetch and load/store requesters.
// Tracks in-order read tags to steer responses back to their issuer.
module cache_port_arbiter #(
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 32,
  parameter int OUTSTANDING = 4,
  parameter int MAX_STREAK  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   f_addr_i,
  input  logic                f_read_i,
  output logic                f_waitrequest_o,
  output logic [DATA_W-1:0]   f_readdata_o,
  output logic                f_readdata_valid_o,
  input  logic                f_flush_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W/8-1:0] d_byte_en_i,
  input  logic [DATA_W-1:0]   d_writedata_i,
  input  logic                d_read_i,
  input  logic                d_write_i,
  output logic                d_waitrequest_o,
  output logic [DATA_W-1:0]   d_readdata_o,
  output logic                d_readdata_valid_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W/8-1:0] m_byte_en_o,
  output logic [DATA_W-1:0]   m_writedata_o,
  output logic                m_read_o,
  output logic                m_write_o,
  input  logic [DATA_W-1:0]   m_readdata_i,
  input  logic                m_readdata_valid_i,
  input  logic                m_waitrequest_i,
  output logic                resp_err_o
);
  localparam int PW = $clog2(OUTSTANDING);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(MAX_STREAK + 1);

  logic [PW-1:0]          wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SW-1:0]          streak_q, streak_d;
  logic [OUTSTANDING-1:0] src_q, src_d;
  logic [OUTSTANDING-1:0] drop_q, drop_d;
  logic                   err_q, err_d;

  logic full, cap, f_req, d_rd, d_req;
  logic f_gnt, d_gnt, f_acc, d_acc;
  logic push, pop, empty;

  assign full  = cnt_q == CW'(OUTSTANDING);
  assign empty = cnt_q == '0;
  assign cap   = streak_q == SW'(MAX_STREAK);

  // A write takes precedence over a read raised in the same cycle
  assign f_req = f_read_i & ~f_flush_i & ~full;
  assign d_rd  = d_read_i & ~d_write_i & ~full;
  assign d_req = d_write_i | d_rd;
  assign f_gnt = f_req & (~d_req | cap);
  assign d_gnt = d_req & ~f_gnt;
  assign f_acc = f_gnt & ~m_waitrequest_i;
  assign d_acc = d_gnt & ~m_waitrequest_i;

  assign push = f_acc | (d_acc & d_rd);
  assign pop  = m_readdata_valid_i & ~empty;

  assign m_read_o      = f_gnt | (d_gnt & d_rd);
  assign m_write_o     = d_gnt & d_write_i;
  assign m_addr_o      = f_gnt ? f_addr_i : d_addr_i;
  assign m_byte_en_o   = f_gnt ? '0 : d_byte_en_i;
  assign m_writedata_o = f_gnt ? '0 : d_writedata_i;

  assign f_waitrequest_o = m_waitrequest_i | ~f_gnt;
  assign d_waitrequest_o = m_waitrequest_i | ~d_gnt;

  assign f_readdata_o       = m_readdata_i;
  assign d_readdata_o       = m_readdata_i;
  assign f_readdata_valid_o = pop & src_q[rd_q] & ~drop_q[rd_q];
  assign d_readdata_valid_o = pop & ~src_q[rd_q];
  assign resp_err_o         = err_q;

  always_comb begin
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    src_d    = src_q;
    drop_d   = drop_q;
    streak_d = streak_q;
    err_d    = err_q | (m_readdata_valid_i & empty);
    if (f_flush_i) drop_d = drop_q | src_q;
    if (push) begin
      wr_d         = wr_q + PW'(1);
      src_d[wr_q]  = f_acc;
      drop_d[wr_q] = f_flush_i & f_acc;
    end
    if (pop) rd_d = rd_q + PW'(1);
    if (!f_read_i || f_acc) streak_d = '0;
    else if (d_acc && !cap) streak_d = streak_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      src_q    <= '0;
      drop_q   <= '0;
      streak_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      src_q    <= src_d;
      drop_q   <= drop_d;
      streak_q <= streak_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_cache_port_arbiter.sv
// Randomized and directed bench for cache_port_arbiter.
// A queue-based reference model predicts grants and response steering.
module tb_cache_port_arbiter;
  localparam int AW = 25;
  localparam int DW = 32;
  localparam int OUT = 4;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] f_addr, d_addr, m_addr;
  logic f_read, f_flush, f_wait, f_rv;
  logic [DW-1:0] f_rd, d_rd, d_wd, m_wd, m_rdata;
  logic [3:0] d_be, m_be;
  logic d_read, d_write, d_wait, d_rv;
  logic m_read, m_write, m_rvalid, m_wait, resp_err;

  always #5 clk = ~clk;

  cache_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .OUTSTANDING(OUT), .MAX_STREAK(MAXS)
  ) dut (
    .clk(clk), .rst(rst),
    .f_addr_i(f_addr), .f_read_i(f_read),
    .f_waitrequest_o(f_wait), .f_readdata_o(f_rd),
    .f_readdata_valid_o(f_rv), .f_flush_i(f_flush),
    .d_addr_i(d_addr), .d_byte_en_i(d_be),
    .d_writedata_i(d_wd), .d_read_i(d_read),
    .d_write_i(d_write), .d_waitrequest_o(d_wait),
    .d_readdata_o(d_rd), .d_readdata_valid_o(d_rv),
    .m_addr_o(m_addr), .m_byte_en_o(m_be),
    .m_writedata_o(m_wd), .m_read_o(m_read),
    .m_write_o(m_write), .m_readdata_i(m_rdata),
    .m_readdata_valid_i(m_rvalid),
    .m_waitrequest_i(m_wait), .resp_err_o(resp_err)
  );

  typedef struct {
    bit f;
    bit d;
    bit drop;
    logic [DW-1:0] data;
  } ent_t;

  ent_t mq[$];
  ent_t exp_q[$];
  int streak;
  bit err;
  int n_chk = 0;
  int n_fail = 0;
  logic last_fw;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    ent_t e;
    if (!rst && (exp_q.size() > 0 || f_rv || d_rv)) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", {62'b0, f_rv, d_rv}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_fvalid", 64'(f_rv), 64'(e.f));
        chk("resp_dvalid", 64'(d_rv), 64'(e.d));
        if (e.f) chk("resp_fdata", 64'(f_rd), 64'(e.data));
        if (e.d) chk("resp_ddata", 64'(d_rd), 64'(e.data));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    f_read = 0; f_flush = 0; d_read = 0; d_write = 0;
    m_rvalid = 0; m_wait = 0;
    f_addr = '0; d_addr = '0; d_be = '0; d_wd = '0; m_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    streak = 0;
    err = 0;
  endtask

  task automatic step(input bit fr, input logic [AW-1:0] fa, input bit fl,
                      input bit dr, input bit dw, input logic [AW-1:0] da,
                      input logic [3:0] be, input logic [DW-1:0] wd,
                      input bit mw, input bit rsp);
    bit full, freq, dreq, drd, fg, dg, acc;
    ent_t e, n;
    f_read = fr; f_addr = fa; f_flush = fl;
    d_read = dr; d_write = dw; d_addr = da; d_be = be; d_wd = wd;
    m_wait = mw;
    full = mq.size() == OUT;
    freq = fr && !fl && !full;
    drd  = dr && !dw && !full;
    dreq = dw || drd;
    fg = freq && (!dreq || streak == MAXS);
    dg = dreq && !fg;
    m_rvalid = rsp;
    if (rsp) begin
      if (mq.size() > 0) begin
        e = mq[0];
        e.f = mq[0].f && !mq[0].drop;
        e.d = !mq[0].f;
      end else begin
        e.f = 0; e.d = 0; e.drop = 0; e.data = $urandom;
      end
      m_rdata = e.data;
      exp_q.push_back(e);
    end
    #3;
    chk("m_rw", {62'b0, m_read, m_write},
        {62'b0, fg || (dg && drd), dg && dw});
    if (fg || dg) begin
      chk("m_addr", 64'(m_addr), 64'(fg ? fa : da));
      chk("m_be_wd", {28'b0, m_be, m_wd},
          fg ? 64'd0 : {28'b0, be, wd});
    end
    chk("waitreq", {62'b0, f_wait, d_wait},
        {62'b0, mw || !fg, mw || !dg});
    chk("resp_err", 64'(resp_err), 64'(err));
    last_fw = f_wait;
    @(posedge clk);
    #1;
    acc = !mw;
    if (rsp) begin
      if (mq.size() > 0) void'(mq.pop_front());
      else err = 1;
    end
    if (fl) foreach (mq[i]) if (mq[i].f) mq[i].drop = 1;
    if (acc && (fg || (dg && drd))) begin
      n.f = fg; n.d = !fg; n.drop = 0; n.data = $urandom;
      mq.push_back(n);
    end
    if (!fr || (fg && acc)) streak = 0;
    else if (dg && acc && streak < MAXS) streak++;
    m_rvalid = 0;
  endtask

  task automatic idle(input bit rsp);
    step(0, '0, 0, 0, 0, '0, '0, '0, 0, rsp);
  endtask

  initial begin
    do_reset();
    idle(0);

    // fetch-only burst, responses two cycles later
    for (int i = 0; i < 3; i++)
      step(1, AW'(32'h10 + i), 0, 0, 0, '0, '0, '0, 0, 0);
    idle(0); idle(0);
    repeat (3) idle(1);

    // contention: D,D,D,D,F repeating
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1, AW'(i), 0, 1, 0, AW'(100 + i), '0, '0, 0, mq.size() > 0);
      chk("contend_pat", 64'(last_fw), 64'((i % 5) != 4));
    end
    while (mq.size() > 0) idle(1);

    // interleaved routing D,F,D
    step(0, '0, 0, 1, 0, AW'(1), '0, '0, 0, 0);
    step(1, AW'(2), 0, 0, 0, '0, '0, '0, 0, 0);
    step(0, '0, 0, 1, 0, AW'(3), '0, '0, 0, 0);
    repeat (3) idle(1);

    // full stall, write while full, resume after a response
    for (int i = 0; i < 5; i++)
      step(1, AW'(i), 0, 0, 0, '0, '0, '0, 0, 0);
    step(1, AW'(9), 0, 0, 1, AW'(7), 4'hf, 32'hdead, 0, 0);
    step(1, AW'(9), 0, 0, 0, '0, '0, '0, 0, 1);
    step(1, AW'(9), 0, 0, 0, '0, '0, '0, 0, 0);
    repeat (4) idle(1);

    // flush drops in-flight fetch responses
    for (int i = 0; i < 3; i++)
      step(1, AW'(i), 0, 0, 0, '0, '0, '0, 0, 0);
    step(1, AW'(5), 1, 0, 0, '0, '0, '0, 0, 0);
    repeat (3) idle(1);
    step(1, AW'(6), 0, 0, 0, '0, '0, '0, 0, 0);
    idle(1);

    // stray response is sticky until reset
    idle(1);
    idle(0);
    step(0, '0, 0, 1, 0, AW'(4), '0, '0, 0, 0);
    idle(1);
    chk("err_sticky", 64'(resp_err), 64'd1);

    // reset mid-operation drops tags
    do_reset();
    step(1, AW'(1), 0, 0, 0, '0, '0, '0, 0, 0);
    step(0, '0, 0, 1, 0, AW'(2), '0, '0, 0, 0);
    do_reset();
    idle(0);
    idle(1);
    idle(0);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 2) != 0, AW'($urandom),
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
           AW'($urandom), 4'($urandom), $urandom,
           $urandom_range(0, 4) == 0,
           mq.size() > 0 && $urandom_range(0, 2) == 0);
    end
    while (mq.size() > 0) idle(1);
    idle(0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
